// File: rtl/escalonador_tanque_pkg.sv
// Shared definitions for the tank sequencer: state encoding and tank level codes.
package escalonador_tanque_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_ENCHER  = 3'b001,
        ST_REGA    = 3'b010,
        ST_MISTURA = 3'b011,
        ST_LIMPEZA = 3'b100,
        ST_PAUSA   = 3'b101,
        ST_FALHA   = 3'b110
    } estado_t;

    localparam logic [1:0] NV_VAZIO = 2'b00;
    localparam logic [1:0] NV_BAIXO = 2'b01;
    localparam logic [1:0] NV_MEIO  = 2'b10;
    localparam logic [1:0] NV_CHEIO = 2'b11;

endpackage

// File: rtl/escalonador_tanque_gerador_tick.sv
// Prescaler: one-cycle tick every TICKS_PER_SEC cycles, restartable by a synchronous clear.
module gerador_tick #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // tick is purely registered so the clear path cannot loop back into it
    assign tick_o = (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/escalonador_tanque.sv
// Tank sequencer: arbitrates refill, irrigation and fertiliser mixing/cleaning with timed states.
module escalonador_tanque
    import escalonador_tanque_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_REGA_S    = 15,
    parameter int MIST_S        = 5,
    parameter int LIMP_S        = 3,
    parameter int PAUSA_S       = 2,
    parameter int FILL_S        = 30
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Us,
    input  logic       Modo,
    input  logic       Adub,
    input  logic [1:0] Nv,
    output logic       Ve,
    output logic       A,
    output logic       G,
    output logic       Mist,
    output logic       Limp,
    output logic       Erro,
    output logic [2:0] Estado,
    output logic [3:0] Tempo
);

    localparam logic [7:0] L_REGA  = 8'(MAX_REGA_S);
    localparam logic [7:0] L_MIST  = 8'(MIST_S);
    localparam logic [7:0] L_LIMP  = 8'(LIMP_S);
    localparam logic [7:0] L_PAUSA = 8'(PAUSA_S);
    localparam logic [7:0] L_FILL  = 8'(FILL_S);

    estado_t    estado_q, estado_d;
    logic       pend_q, pend_d;
    logic [7:0] seg_q, seg_d;
    logic       tick;
    logic       entrada;
    logic       pend_ef;
    logic       fim;
    logic [7:0] limite;
    logic [7:0] resto;

    gerador_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk_i (Clk),
        .rst_i (Rst),
        .clr_i (entrada),
        .tick_o(tick)
    );

    always_comb begin
        limite = 8'd0;
        case (estado_q)
            ST_ENCHER:  limite = L_FILL;
            ST_REGA:    limite = L_REGA;
            ST_MISTURA: limite = L_MIST;
            ST_LIMPEZA: limite = L_LIMP;
            ST_PAUSA:   limite = L_PAUSA;
            default:    limite = 8'd0;
        endcase
    end

    // the last tick of the final second ends the state, giving exactly N*TICKS_PER_SEC cycles
    assign fim     = tick && ((seg_q + 8'd1) >= limite);
    assign pend_ef = pend_q | Adub;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE: begin
                if (pend_ef && (Nv >= NV_MEIO)) begin
                    estado_d = ST_MISTURA;
                end else if (Nv < NV_MEIO) begin
                    estado_d = ST_ENCHER;
                end else if (Us) begin
                    estado_d = ST_REGA;
                end
            end
            ST_ENCHER: begin
                if (Nv == NV_CHEIO) begin
                    estado_d = ST_IDLE;
                end else if (fim) begin
                    estado_d = ST_FALHA;
                end
            end
            ST_REGA: begin
                if (!Us || (Nv == NV_VAZIO) || fim || pend_ef) begin
                    estado_d = ST_PAUSA;
                end
            end
            ST_MISTURA: if (fim) estado_d = ST_LIMPEZA;
            ST_LIMPEZA: if (fim) estado_d = ST_PAUSA;
            ST_PAUSA:   if (fim) estado_d = ST_IDLE;
            ST_FALHA:   estado_d = ST_FALHA;
            default:    estado_d = ST_IDLE;
        endcase
    end

    assign entrada = (estado_d != estado_q);

    always_comb begin
        pend_d = pend_ef;
        // a request coinciding with the entry edge is absorbed by this mixing cycle
        if (entrada && (estado_d == ST_MISTURA)) begin
            pend_d = 1'b0;
        end
        seg_d = seg_q;
        if (entrada) begin
            seg_d = 8'd0;
        end else if (tick && (limite != 8'd0)) begin
            seg_d = seg_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            estado_q <= ST_IDLE;
            pend_q   <= 1'b0;
            seg_q    <= 8'd0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        Ve   = 1'b0;
        A    = 1'b0;
        G    = 1'b0;
        Mist = 1'b0;
        Limp = 1'b0;
        Erro = 1'b0;
        case (estado_q)
            ST_ENCHER:  Ve   = 1'b1;
            ST_REGA: begin
                A = Modo;
                G = ~Modo;
            end
            ST_MISTURA: Mist = 1'b1;
            ST_LIMPEZA: Limp = 1'b1;
            ST_FALHA:   Erro = 1'b1;
            default: ;
        endcase
    end

    assign resto  = limite - seg_q;
    assign Estado = estado_q;
    assign Tempo  = (limite == 8'd0) ? 4'd0 :
                    (resto > 8'd15)  ? 4'd15 : resto[3:0];

endmodule
